// File: rtl/z80_alu16_seq_pkg.sv
// Shared definitions for the slice-serial 16-bit ALU: flag bit indices,
// mode codes, sequencer state encoding and small mode-decode helpers.
// Pure declarations, no logic or timing of its own.
package z80_alu16_seq_pkg;

  // Bit positions inside the F register
  localparam int FLAG_C_NUM  = 0;
  localparam int FLAG_N_NUM  = 1;
  localparam int FLAG_PV_NUM = 2;
  localparam int FLAG_3_NUM  = 3;
  localparam int FLAG_H_NUM  = 4;
  localparam int FLAG_5_NUM  = 5;
  localparam int FLAG_Z_NUM  = 6;
  localparam int FLAG_S_NUM  = 7;

  // Register-pair arithmetic mode codes
  localparam logic [1:0] ALU16_ADD = 2'b00;
  localparam logic [1:0] ALU16_ADC = 2'b01;
  localparam logic [1:0] ALU16_SUB = 2'b10;
  localparam logic [1:0] ALU16_SBC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alu16_state_t;

  // Subtracting modes invert operand 2 and report borrow instead of carry
  function automatic logic mode_is_sub(input logic [1:0] m);
    return (m == ALU16_SUB) || (m == ALU16_SBC);
  endfunction

  // Modes that consume the incoming C flag and compute S/Z/PV themselves
  function automatic logic mode_uses_cin(input logic [1:0] m);
    return (m == ALU16_ADC) || (m == ALU16_SBC);
  endfunction

endpackage

// File: rtl/z80_alu_slice.sv
// Combinational SLICE-bit adder/subtractor slice with internal carry taps.
// Latency: zero (purely combinational).
// Backpressure: none; the caller sequences slices.
module z80_alu_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_into_msb,
  output logic             c_into_bit
);

  logic [SLICE-1:0] bx;
  logic [SLICE:0]   tot;

  assign bx   = b ^ {SLICE{sub}};
  assign tot  = {1'b0, a} + {1'b0, bx} + {{SLICE{1'b0}}, cin};
  assign sum  = tot[SLICE-1:0];
  assign cout = tot[SLICE];

  // The carry into any bit is recovered as sum ^ a ^ b at that bit
  assign c_into_msb = sum[SLICE-1] ^ a[SLICE-1] ^ bx[SLICE-1];
  assign c_into_bit = sum[SLICE-4] ^ a[SLICE-4] ^ bx[SLICE-4];

endmodule

// File: rtl/z80_alu16_seq.sv
// Slice-serial ADD/ADC/SUB/SBC for register pairs, SLICE bits per clock, LSB first.
// Latency: start accepted in cycle 0 -> busy cycles 1..NSLICE, done pulse cycle NSLICE+1.
// Backpressure: start ignored while busy; accepted again in IDLE or DONE.
// Optional macro Z80_UNDOC_FLAGS_EN: F5/F3 taken from result bits WIDTH-3/WIDTH-5.
module z80_alu16_seq
  import z80_alu16_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [7:0]       f_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [7:0]       f_out
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  alu16_state_t state_q, state_d;
  logic         accept, last;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_next;
  logic [1:0]       mode_q;
  logic             carry_q, zacc_q;
  logic             fs_q, fz_q, fpv_q;

  logic [SLICE-1:0] a_sl, b_sl, sum_sl;
  logic             cout_sl, cmsb_sl, cbit_sl;
  logic             sub_q, full_q;
  logic [7:0]       f_next;

`ifdef Z80_UNDOC_FLAGS_EN
  logic unused_f_in;
  assign unused_f_in = ^{f_in[5], f_in[4], f_in[3], f_in[1]};
`else
  logic f5_q, f3_q;
  logic unused_f_in;
  assign unused_f_in = ^{f_in[4], f_in[1]};
`endif

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

  assign sub_q  = mode_is_sub(mode_q);
  assign full_q = mode_uses_cin(mode_q);

  assign a_sl = a_q[int'(cnt_q)*SLICE +: SLICE];
  assign b_sl = b_q[int'(cnt_q)*SLICE +: SLICE];

  z80_alu_slice #(.SLICE(SLICE)) u_slice (
    .a          (a_sl),
    .b          (b_sl),
    .cin        (carry_q),
    .sub        (sub_q),
    .sum        (sum_sl),
    .cout       (cout_sl),
    .c_into_msb (cmsb_sl),
    .c_into_bit (cbit_sl)
  );

  assign acc_next = acc_q | (WIDTH'(sum_sl) << (int'(cnt_q) * SLICE));

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode: accept in IDLE/DONE, leave RUN after the top slice
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == CW'(NSLICE - 1)) begin
          last    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Flag assembly for the top slice; H and C are reported as borrow when subtracting
  always_comb begin
    f_next              = 8'h00;
    f_next[FLAG_S_NUM]  = full_q ? acc_next[WIDTH-1] : fs_q;
    f_next[FLAG_Z_NUM]  = full_q ? (zacc_q & (sum_sl == '0)) : fz_q;
    f_next[FLAG_PV_NUM] = full_q ? (cmsb_sl ^ cout_sl) : fpv_q;
    f_next[FLAG_H_NUM]  = cbit_sl ^ sub_q;
    f_next[FLAG_N_NUM]  = sub_q;
    f_next[FLAG_C_NUM]  = cout_sl ^ sub_q;
`ifdef Z80_UNDOC_FLAGS_EN
    f_next[FLAG_5_NUM]  = acc_next[WIDTH-3];
    f_next[FLAG_3_NUM]  = acc_next[WIDTH-5];
`else
    f_next[FLAG_5_NUM]  = f5_q;
    f_next[FLAG_3_NUM]  = f3_q;
`endif
  end

  // Operand latch, slice iteration and result/flag update
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      mode_q  <= 2'b00;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      fs_q    <= 1'b0;
      fz_q    <= 1'b0;
      fpv_q   <= 1'b0;
`ifndef Z80_UNDOC_FLAGS_EN
      f5_q    <= 1'b0;
      f3_q    <= 1'b0;
`endif
      result  <= '0;
      f_out   <= 8'h00;
    end else if (accept) begin
      cnt_q   <= '0;
      a_q     <= a_in;
      b_q     <= b_in;
      acc_q   <= '0;
      mode_q  <= mode;
      // Subtraction is a + ~b + 1 - borrow, so the chain is seeded with the inverted borrow
      carry_q <= (mode_uses_cin(mode) & f_in[FLAG_C_NUM]) ^ mode_is_sub(mode);
      zacc_q  <= 1'b1;
      fs_q    <= f_in[FLAG_S_NUM];
      fz_q    <= f_in[FLAG_Z_NUM];
      fpv_q   <= f_in[FLAG_PV_NUM];
`ifndef Z80_UNDOC_FLAGS_EN
      f5_q    <= f_in[FLAG_5_NUM];
      f3_q    <= f_in[FLAG_3_NUM];
`endif
    end else if (state_q == ST_RUN) begin
      carry_q <= cout_sl;
      zacc_q  <= zacc_q & (sum_sl == '0);
      acc_q   <= acc_next;
      cnt_q   <= last ? '0 : cnt_q + CW'(1);
      if (last) begin
        result <= acc_next;
        f_out  <= f_next;
      end
    end
  end

endmodule

// File: tb/tb_z80_alu16_seq.sv
module tb_z80_alu16_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start16, start32;
  logic [1:0]  mode16, mode32;
  logic [15:0] a16, b16, res16;
  logic [31:0] a32, b32, res32;
  logic [7:0]  f16, f32, fo16, fo32;
  logic        busy16, done16, busy32, done32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  z80_alu16_seq #(.WIDTH(16), .SLICE(8)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .mode(mode16),
    .a_in(a16), .b_in(b16), .f_in(f16),
    .busy(busy16), .done(done16), .result(res16), .f_out(fo16)
  );

  z80_alu16_seq #(.WIDTH(32), .SLICE(8)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .mode(mode32),
    .a_in(a32), .b_in(b32), .f_in(f32),
    .busy(busy32), .done(done32), .result(res32), .f_out(fo32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operand width
  function automatic void model(input int w, input logic [1:0] m,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [7:0] fi,
                                output logic [63:0] r, output logic [7:0] fo);
    logic [63:0] mask, hm, full;
    logic        sub, cin, c, h, v;
    mask = (64'd1 << w) - 64'd1;
    hm   = (64'd1 << (w - 4)) - 64'd1;
    sub  = m[1];
    cin  = m[0] ? fi[0] : 1'b0;
    if (!sub) begin
      full = a + b + 64'(cin);
      c    = full[w];
      h    = (((a & hm) + (b & hm) + 64'(cin)) >> (w - 4)) != 0;
      r    = full & mask;
      v    = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
    end else begin
      full = a - b - 64'(cin);
      c    = a < (b + 64'(cin));
      h    = (a & hm) < ((b & hm) + 64'(cin));
      r    = full & mask;
      v    = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
    end
    fo    = 8'h00;
    fo[7] = m[0] ? r[w-1] : fi[7];
    fo[6] = m[0] ? (r == 0) : fi[6];
    fo[2] = m[0] ? v : fi[2];
    fo[4] = h;
    fo[1] = sub;
    fo[0] = c;
`ifdef Z80_UNDOC_FLAGS_EN
    fo[5] = r[w-3];
    fo[3] = r[w-5];
`else
    fo[5] = fi[5];
    fo[3] = fi[3];
`endif
  endfunction

  // One 16-bit operation launched at a negedge; checks latency, busy, done width, result, flags
  task automatic run16(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] f, input string tag,
                       output logic [15:0] r_obs, output logic [7:0] f_obs);
    logic [63:0] er;
    logic [7:0]  ef;
    int n;
    model(16, m, 64'(a), 64'(b), f, er, ef);
    start16 = 1'b1; mode16 = m; a16 = a; b16 = b; f16 = f;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start16 = 1'b0;
        chk({tag, "_busy"}, 64'(busy16), 64'd1);
      end
    end while (!done16 && n < 12);
    chk({tag, "_lat"}, 64'(n), 64'd3);
    r_obs = res16;
    f_obs = fo16;
    chk({tag, "_res"}, 64'(res16), er);
    chk({tag, "_f"}, 64'(fo16), 64'(ef));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(done16), 64'd0);
  endtask

  initial begin
    logic [15:0] r;
    logic [7:0]  fo;
    logic [8:0]  done_v, busy_v;
    logic [15:0] rA, rB;
    logic [63:0] er, er2;
    logic [7:0]  ef, ef2;
    int n;

    reset = 1'b1;
    start16 = 1'b0; mode16 = 2'b00; a16 = '0; b16 = '0; f16 = '0;
    start32 = 1'b0; mode32 = 2'b00; a32 = '0; b32 = '0; f32 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy16), 64'd0);
    chk("rst_done", 64'(done16), 64'd0);
    chk("rst_res", 64'(res16), 64'd0);
    chk("rst_f", 64'(fo16), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases with literal expectations
    run16(2'b00, 16'h0FFF, 16'h0001, 8'hC4, "add1", r, fo);
    chk("add1_lit_res", 64'(r), 64'h1000);
    chk("add1_lit_f", 64'(fo), 64'hD4);
    run16(2'b01, 16'h7FFF, 16'h0000, 8'h01, "adc2", r, fo);
    chk("adc2_lit_res", 64'(r), 64'h8000);
    chk("adc2_lit_f", 64'(fo), 64'h94);
    run16(2'b11, 16'h0000, 16'h0001, 8'h00, "sbc3", r, fo);
    chk("sbc3_lit_res", 64'(r), 64'hFFFF);
`ifdef Z80_UNDOC_FLAGS_EN
    chk("sbc3_lit_f", 64'(fo), 64'hBB);
`else
    chk("sbc3_lit_f", 64'(fo), 64'h93);
`endif
    run16(2'b11, 16'h1234, 16'h1233, 8'h01, "sbc4", r, fo);
    chk("sbc4_lit_res", 64'(r), 64'h0000);
    chk("sbc4_lit_f", 64'(fo), 64'h42);
    run16(2'b00, 16'hFFFF, 16'h0001, 8'h00, "wrap", r, fo);
    chk("wrap_lit_res", 64'(r), 64'h0000);
    chk("wrap_lit_c", 64'(fo[0]), 64'd1);
    run16(2'b10, 16'h8000, 16'h0001, 8'hFF, "sub_ovf", r, fo);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      run16(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 8'($urandom),
            $sformatf("rnd%0d", i), r, fo);
    end

    // Handshake: start held cycles 0..3, inputs changed while busy
    model(16, 2'b00, 64'h1111, 64'h2222, 8'h00, er, ef);
    model(16, 2'b11, 64'h5000, 64'h0123, 8'h01, er2, ef2);
    done_v = '0; busy_v = '0; rA = '0; rB = '0;
    for (int c = 0; c < 9; c++) begin
      done_v[c] = done16;
      busy_v[c] = busy16;
      if (c == 3) rA = res16;
      if (c == 6) rB = res16;
      case (c)
        0:       begin start16 = 1'b1; mode16 = 2'b00; a16 = 16'h1111; b16 = 16'h2222; f16 = 8'h00; end
        1, 2:    begin start16 = 1'b1; mode16 = 2'b10; a16 = 16'hFFFF; b16 = 16'h0001; f16 = 8'hFF; end
        3:       begin start16 = 1'b1; mode16 = 2'b11; a16 = 16'h5000; b16 = 16'h0123; f16 = 8'h01; end
        default: start16 = 1'b0;
      endcase
      @(negedge clk);
    end
    chk("hs_done_pattern", 64'(done_v), 64'b001001000);
    chk("hs_busy_pattern", 64'(busy_v), 64'b000110110);
    chk("hs_resA", 64'(rA), er);
    chk("hs_resB", 64'(rB), er2);
    chk("hs_fB", 64'(fo16), 64'(ef2));

    // Reset in cycle 1 of a run aborts it
    start16 = 1'b1; mode16 = 2'b00; a16 = 16'h0101; b16 = 16'h0202; f16 = 8'hFF;
    @(negedge clk);
    start16 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy16), 64'd0);
    chk("abort_done", 64'(done16), 64'd0);
    chk("abort_res", 64'(res16), 64'd0);
    chk("abort_f", 64'(fo16), 64'd0);
    done_v = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      done_v[c] = done16;
    end
    chk("abort_no_done", 64'(done_v), 64'd0);

    // 32-bit instance: wrap-around and NSLICE=4 latency
    model(32, 2'b00, 64'hFFFFFFFF, 64'h1, 8'h00, er, ef);
    start32 = 1'b1; mode32 = 2'b00; a32 = 32'hFFFFFFFF; b32 = 32'h1; f32 = 8'h00;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) start32 = 1'b0;
    end while (!done32 && n < 12);
    chk("w32_lat", 64'(n), 64'd5);
    chk("w32_res", 64'(res32), 64'd0);
    chk("w32_c", 64'(fo32[0]), 64'd1);
    chk("w32_f", 64'(fo32), 64'(ef));
    run16(2'b01, 16'hFFFF, 16'h0000, 8'h01, "adc_tail", r, fo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
